epl_accumulator: RTL and testbench

- Correlator integrate-and-dump stage, directly downstream of the C/A code generator in each tracking channel.
- Multiplies the carrier-wiped baseband I/Q samples by the early, prompt and late chips.
- Integrates six products (IE, QE, IP, QP, IL, QL) and dumps them to output registers on each dump_enable.
- Flags new results to the bus-side reader with a ready/read handshake.

---
 rtl/epl_pkg.sv | 39 +++
 rtl/epl_acc_channel.sv | 44 ++++
 rtl/epl_accumulator.sv | 92 +++++++++
 tb/tb_epl_accumulator.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/epl_pkg.sv
// Shared definitions for the early/prompt/late correlator accumulator.
// SATURATE_EN selects clamping instead of wrap-around in the accumulators.
package epl_pkg;

   localparam int IN_W_DEF  = 3;
   localparam int ACC_W_DEF = 16;

   typedef enum logic [1:0] {
      ARM_EARLY  = 2'd0,
      ARM_PROMPT = 2'd1,
      ARM_LATE   = 2'd2
   } epl_arm_e;

   // Chip 0 passes the sample, chip 1 negates it; the caller sign-extends
   // first so that negating the most negative sample cannot overflow.
   function automatic logic signed [31:0] chip_mul(input logic signed [31:0] s,
                                                   input logic chip);
      return chip ? -s : s;
   endfunction

   // Adds two values that each fit in w bits and clamps the sum to w bits.
   function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                  input logic signed [31:0] b,
                                                  input int w);
      logic signed [32:0] s;
      logic signed [32:0] hi;
      logic signed [32:0] lo;
      s  = 33'(a) + 33'(b);
      hi = (33'sd1 <<< (w - 1)) - 33'sd1;
      lo = -(33'sd1 <<< (w - 1));
      if (s > hi)
         return hi[31:0];
      else if (s < lo)
         return lo[31:0];
      else
         return s[31:0];
   endfunction

endpackage

// File: rtl/epl_acc_channel.sv
// One integrate-and-dump lane: signed accumulator plus its dump register.
// SATURATE_EN makes the adder clamp instead of wrap.
module epl_acc_channel
   import epl_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic signed [ACC_W-1:0] contrib,
   input  logic                    valid,
   input  logic                    dump,
   input  logic                    clear,
   output logic signed [ACC_W-1:0] dump_q
);

   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] add_v;
   logic signed [ACC_W-1:0] sum;

   assign add_v = valid ? contrib : '0;

`ifdef SATURATE_EN
   assign sum = ACC_W'(sat_add(32'(acc), 32'(add_v), ACC_W));
`else
   assign sum = acc + add_v;
`endif

   // Clear outranks dump: a clear on the epoch discards the period silently.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         acc    <= '0;
         dump_q <= '0;
      end else if (clear) begin
         acc <= '0;
      end else if (dump) begin
         dump_q <= sum;
         acc    <= '0;
      end else if (valid) begin
         acc <= sum;
      end
   end

endmodule

// File: rtl/epl_accumulator.sv
// Correlator integrate-and-dump for the E/P/L arms with a ready/read flag pair.
// Define SATURATE_EN to clamp the accumulators instead of wrapping.
module epl_accumulator
   import epl_pkg::*;
#(
   parameter int IN_W  = IN_W_DEF,
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    sample_enable,
   input  logic signed [IN_W-1:0]  i_bb,
   input  logic signed [IN_W-1:0]  q_bb,
   input  logic                    early,
   input  logic                    prompt,
   input  logic                    late,
   input  logic                    dump_enable,
   input  logic                    acc_clear,
   input  logic                    read_strobe,
   output logic signed [ACC_W-1:0] i_early,
   output logic signed [ACC_W-1:0] q_early,
   output logic signed [ACC_W-1:0] i_prompt,
   output logic signed [ACC_W-1:0] q_prompt,
   output logic signed [ACC_W-1:0] i_late,
   output logic signed [ACC_W-1:0] q_late,
   output logic                    accum_ready,
   output logic                    dump_missed
);

   logic [2:0]              chip_vec;
   logic signed [ACC_W-1:0] i_sum [3];
   logic signed [ACC_W-1:0] q_sum [3];
   logic                    do_dump;

   assign chip_vec = {late, prompt, early};
   assign do_dump  = dump_enable & ~acc_clear;

   for (genvar a = 0; a < 3; a++) begin : g_arm
      logic signed [ACC_W-1:0] i_contrib;
      logic signed [ACC_W-1:0] q_contrib;

      assign i_contrib = ACC_W'(chip_mul(32'(i_bb), chip_vec[a]));
      assign q_contrib = ACC_W'(chip_mul(32'(q_bb), chip_vec[a]));

      epl_acc_channel #(.ACC_W(ACC_W)) u_i (
         .clk    (clk),
         .rstn   (rstn),
         .contrib(i_contrib),
         .valid  (sample_enable),
         .dump   (dump_enable),
         .clear  (acc_clear),
         .dump_q (i_sum[a])
      );

      epl_acc_channel #(.ACC_W(ACC_W)) u_q (
         .clk    (clk),
         .rstn   (rstn),
         .contrib(q_contrib),
         .valid  (sample_enable),
         .dump   (dump_enable),
         .clear  (acc_clear),
         .dump_q (q_sum[a])
      );
   end

   assign i_early  = i_sum[ARM_EARLY];
   assign q_early  = q_sum[ARM_EARLY];
   assign i_prompt = i_sum[ARM_PROMPT];
   assign q_prompt = q_sum[ARM_PROMPT];
   assign i_late   = i_sum[ARM_LATE];
   assign q_late   = q_sum[ARM_LATE];

   // Handshake: ready is set by a dump (set beats a coincident read) and
   // cleared by a read; a dump over unread results is remembered until read.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         accum_ready <= 1'b0;
         dump_missed <= 1'b0;
      end else begin
         if (do_dump)
            accum_ready <= 1'b1;
         else if (read_strobe)
            accum_ready <= 1'b0;

         if (do_dump && accum_ready && !read_strobe)
            dump_missed <= 1'b1;
         else if (read_strobe)
            dump_missed <= 1'b0;
      end
   end

endmodule

// File: tb/tb_epl_accumulator.sv
// Directed bench for epl_accumulator: per-cycle comparison against an
// integer-sum model plus literal expectations at key points.
module tb_epl_accumulator;

   localparam int IN_W  = 3;
   localparam int ACC_W = 16;

   logic                    clk = 1'b0;
   logic                    rstn;
   logic                    sample_enable;
   logic signed [IN_W-1:0]  i_bb;
   logic signed [IN_W-1:0]  q_bb;
   logic                    early, prompt, late;
   logic                    dump_enable, acc_clear, read_strobe;
   logic signed [ACC_W-1:0] i_early, q_early, i_prompt, q_prompt, i_late, q_late;
   logic                    accum_ready, dump_missed;

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 1'b0;

   // model state: plain integer running sums, index 0..5 = IE,QE,IP,QP,IL,QL
   int m_acc  [6];
   int m_dump [6];
   bit m_ready;
   bit m_missed;

   epl_accumulator #(.IN_W(IN_W), .ACC_W(ACC_W)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .sample_enable(sample_enable),
      .i_bb         (i_bb),
      .q_bb         (q_bb),
      .early        (early),
      .prompt       (prompt),
      .late         (late),
      .dump_enable  (dump_enable),
      .acc_clear    (acc_clear),
      .read_strobe  (read_strobe),
      .i_early      (i_early),
      .q_early      (q_early),
      .i_prompt     (i_prompt),
      .q_prompt     (q_prompt),
      .i_late       (i_late),
      .q_late       (q_late),
      .accum_ready  (accum_ready),
      .dump_missed  (dump_missed)
   );

   // clock / reset
   always #5 clk = ~clk;

   function automatic int to_acc_w(input int v);
      logic signed [ACC_W-1:0] r;
      r = ACC_W'(v);
      return int'(r);
   endfunction

   function automatic int clamp(input int v);
      int hi, lo;
      hi = (1 << (ACC_W - 1)) - 1;
      lo = -(1 << (ACC_W - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   function automatic int fold(input int v);
`ifdef SATURATE_EN
      return clamp(v);
`else
      return to_acc_w(v);
`endif
   endfunction

   // reference model, advanced on the same edge as the DUT
   always @(posedge clk) begin
      int s_i, s_q;
      int c [6];
      bit ch [3];
      s_i = int'(i_bb);
      s_q = int'(q_bb);
      ch[0] = early; ch[1] = prompt; ch[2] = late;
      for (int a = 0; a < 3; a++) begin
         c[2*a]   = ch[a] ? -s_i : s_i;
         c[2*a+1] = ch[a] ? -s_q : s_q;
         if (!sample_enable) begin
            c[2*a] = 0; c[2*a+1] = 0;
         end
      end
      if (!rstn) begin
         for (int k = 0; k < 6; k++) begin m_acc[k] = 0; m_dump[k] = 0; end
         m_ready = 0; m_missed = 0;
      end else begin
         if (acc_clear) begin
            for (int k = 0; k < 6; k++) m_acc[k] = 0;
         end else if (dump_enable) begin
            for (int k = 0; k < 6; k++) begin
               m_dump[k] = fold(m_acc[k] + c[k]);
               m_acc[k]  = 0;
            end
         end else begin
            for (int k = 0; k < 6; k++) m_acc[k] = fold(m_acc[k] + c[k]);
         end
         if (dump_enable && !acc_clear) begin
            if (m_ready && !read_strobe) m_missed = 1;
            else if (read_strobe) m_missed = 0;
            m_ready = 1;
         end else if (read_strobe) begin
            m_ready = 0; m_missed = 0;
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // compare process on the falling edge
   always @(negedge clk) begin
      if (cmp_en) begin
         check("ie", int'(i_early),  m_dump[0]);
         check("qe", int'(q_early),  m_dump[1]);
         check("ip", int'(i_prompt), m_dump[2]);
         check("qp", int'(q_prompt), m_dump[3]);
         check("il", int'(i_late),   m_dump[4]);
         check("ql", int'(q_late),   m_dump[5]);
         check("ready",  int'(accum_ready), int'(m_ready));
         check("missed", int'(dump_missed), int'(m_missed));
      end
   end

   // driver tasks: one call = one clock cycle of inputs
   task automatic cyc(input logic s, input logic signed [IN_W-1:0] i, input logic signed [IN_W-1:0] q,
                      input logic e, input logic p, input logic l,
                      input logic d, input logic c, input logic r);
      sample_enable = s; i_bb = i; q_bb = q;
      early = e; prompt = p; late = l;
      dump_enable = d; acc_clear = c; read_strobe = r;
      @(posedge clk);
      #1;
   endtask

   task automatic samples(input int n, input logic signed [IN_W-1:0] i, input logic signed [IN_W-1:0] q,
                          input logic e, input logic p, input logic l);
      for (int k = 0; k < n; k++) cyc(1, i, q, e, p, l, 0, 0, 0);
   endtask

   task automatic idle();
      cyc(0, '0, '0, 0, 0, 0, 0, 0, 0);
   endtask
   task automatic dump();
      cyc(0, '0, '0, 0, 0, 0, 1, 0, 0);
   endtask
   task automatic rd();
      cyc(0, '0, '0, 0, 0, 0, 0, 0, 1);
   endtask

   initial begin
      rstn = 1'b0;
      sample_enable = 0; i_bb = '0; q_bb = '0;
      early = 0; prompt = 0; late = 0;
      dump_enable = 0; acc_clear = 0; read_strobe = 0;
      @(posedge clk); @(posedge clk); #1;
      rstn = 1'b1;
      cmp_en = 1'b1;
      check("rst_ie", int'(i_early), 0);
      check("rst_ready", int'(accum_ready), 0);
      check("rst_missed", int'(dump_missed), 0);

      // accumulation: +3 / -2, all chips 0
      samples(10, 3'sd3, -3'sd2, 0, 0, 0);
      dump();
      check("acc_ie", int'(i_early), 30);
      check("acc_qp", int'(q_prompt), -20);
      check("acc_ready", int'(accum_ready), 1);
      rd();
      check("rd_ready", int'(accum_ready), 0);

      // chip sign
      samples(4, 3'sd3, -3'sd2, 1, 0, 1);
      dump();
      check("sign_ie", int'(i_early), -12);
      check("sign_ip", int'(i_prompt), 12);
      check("sign_ql", int'(q_late), 8);
      rd();

      // dump coincident with a sample
      samples(5, 3'sd1, 3'sd0, 0, 0, 0);
      cyc(1, 3'sd1, 3'sd0, 0, 0, 0, 1, 0, 0);
      check("coin_ip", int'(i_prompt), 6);
      rd();
      samples(1, 3'sd1, 3'sd0, 0, 0, 0);
      dump();
      check("next_ip", int'(i_prompt), 1);
      rd();

      // handshake
      dump();
      dump();
      check("miss_set", int'(dump_missed), 1);
      rd();
      check("miss_clr", int'(dump_missed), 0);
      check("miss_rdy", int'(accum_ready), 0);
      dump();
      cyc(0, '0, '0, 0, 0, 0, 1, 0, 1);
      check("set_wins", int'(accum_ready), 1);
      check("no_miss", int'(dump_missed), 0);
      rd();
      rd();

      // acc_clear
      samples(7, 3'sd1, -3'sd1, 0, 0, 0);
      cyc(1, 3'sd1, -3'sd1, 0, 0, 0, 0, 1, 0);
      samples(3, 3'sd1, -3'sd1, 0, 0, 0);
      dump();
      check("clr_ip", int'(i_prompt), 3);
      check("clr_qp", int'(q_prompt), -3);
      rd();
      samples(2, 3'sd2, 3'sd2, 0, 0, 0);
      cyc(0, '0, '0, 0, 0, 0, 1, 1, 0);
      check("clrdump_ip", int'(i_prompt), 3);
      check("clrdump_rdy", int'(accum_ready), 0);
      dump();
      check("after_clr", int'(i_prompt), 0);
      rd();

      // reset mid-integration
      samples(4, 3'sd2, 3'sd1, 0, 0, 0);
      rstn = 1'b0;
      idle();
      rstn = 1'b1;
      check("rst2_ip", int'(i_prompt), 0);
      samples(2, 3'sd2, 3'sd1, 0, 0, 0);
      dump();
      check("post_rst_ip", int'(i_prompt), 4);
      rd();

      // overflow: -4 with prompt chip 1 gives +4, early chip 0 gives -4
      samples(8200, -3'sd4, 3'sd0, 0, 1, 0);
      dump();
`ifdef SATURATE_EN
      check("ovf_ip", int'(i_prompt), 32767);
      check("ovf_ie", int'(i_early), -32768);
`else
      check("ovf_ip", int'(i_prompt), -32736);
      check("ovf_ie", int'(i_early), 32736);
`endif
      rd();
      idle();
      idle();

      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
